// File: rtl/hs_rr_sched.sv
// Clocked round-robin scheduler sharing one 4-phase bundled-data channel
// among N hlatch producer channels.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        asynchronous active-high reset
//   in_req     [N]     producer requests (async, synchronised here)
//   in_ack     [N]     producer acknowledges, at most one bit high
//   in_dat     [N*DW]  producer data, channel i = in_dat[i*DW +: DW]
//   out_req            request to the shared consumer
//   out_ack            consumer acknowledge (async, synchronised here)
//   out_dat    [DW]    data captured at grant time
//   grant_idx  [GW]    index of current / last winner
//   busy               high whenever the FSM is not IDLE
module hs_rr_sched #(
    parameter int N    = 2,
    parameter int DW   = 1,
    parameter int SYNC = 2,
    localparam int GW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_req,
    output logic [N-1:0]    in_ack,
    input  logic [N*DW-1:0] in_dat,
    output logic            out_req,
    input  logic            out_ack,
    output logic [DW-1:0]   out_dat,
    output logic [GW-1:0]   grant_idx,
    output logic            busy
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT_AH,
        WAIT_RL,
        WAIT_AL
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [N-1:0]  req_sync [SYNC];
    logic [SYNC-1:0] ack_sync;
    logic [N-1:0]  sreq;
    logic          sack;

    logic [GW-1:0] ptr;
    logic [GW-1:0] ptr_nxt;
    logic [GW-1:0] ptr_adv;

    logic          win_found;
    logic [GW-1:0] win_idx;
    logic [DW-1:0] win_dat;
    logic          sreq_w;

    logic            out_req_nxt;
    logic [N-1:0]    in_ack_nxt;
    logic [DW-1:0]   out_dat_nxt;
    logic [GW-1:0]   grant_idx_nxt;

    // Plain flop chains; only the last stage is ever looked at.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC; s++) begin
                req_sync[s] <= '0;
            end
            ack_sync <= '0;
        end else begin
            req_sync[0] <= in_req;
            for (int s = 1; s < SYNC; s++) begin
                req_sync[s] <= req_sync[s-1];
            end
            ack_sync <= {ack_sync[SYNC-2:0], out_ack};
        end
    end

    assign sreq   = req_sync[SYNC-1];
    assign sack   = ack_sync[SYNC-1];
    assign sreq_w = sreq[grant_idx];

    // Rotating-priority search starting at ptr; first hit wins.
    always_comb begin
        int c;
        c         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        win_dat   = '0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr) + k;
            if (c >= N) begin
                c = c - N;
            end
            if (!win_found && sreq[c]) begin
                win_found = 1'b1;
                win_idx   = GW'(c);
                win_dat   = in_dat[c*DW +: DW];
            end
        end
    end

    // Winner drops to lowest priority; N=1 degenerates to ptr=0.
    assign ptr_adv = (int'(grant_idx) == N - 1) ? '0
                                                : grant_idx + GW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            out_req   <= 1'b0;
            in_ack    <= '0;
            out_dat   <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            out_req   <= out_req_nxt;
            in_ack    <= in_ack_nxt;
            out_dat   <= out_dat_nxt;
            grant_idx <= grant_idx_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (win_found) state_nxt = SETUP;
            SETUP:   state_nxt = WAIT_AH;
            WAIT_AH: if (sack) state_nxt = WAIT_RL;
            WAIT_RL: if (!sreq_w) state_nxt = WAIT_AL;
            WAIT_AL: if (!sack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_req_nxt   = out_req;
        in_ack_nxt    = in_ack;
        out_dat_nxt   = out_dat;
        grant_idx_nxt = grant_idx;
        ptr_nxt       = ptr;
        unique case (state)
            IDLE: begin
                if (win_found) begin
                    out_dat_nxt   = win_dat;
                    grant_idx_nxt = win_idx;
                end
            end
            // out_dat has been stable a full cycle by now.
            SETUP: begin
                out_req_nxt = 1'b1;
            end
            WAIT_AH: begin
                if (sack) begin
                    in_ack_nxt            = '0;
                    in_ack_nxt[grant_idx] = 1'b1;
                end
            end
            WAIT_RL: begin
                if (!sreq_w) begin
                    out_req_nxt = 1'b0;
                end
            end
            WAIT_AL: begin
                if (!sack) begin
                    in_ack_nxt = '0;
                    ptr_nxt    = ptr_adv;
                end
            end
            default: begin
                out_req_nxt = 1'b0;
                in_ack_nxt  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_hs_rr_sched.sv
// Bench for hs_rr_sched: directed handshake cases, then random
// 4-phase producers/consumer against a round-robin reference model.
`timescale 1ns/1ps
module tb_hs_rr_sched;

    localparam int N      = 4;
    localparam int DW     = 8;
    localparam int SYNC   = 2;
    localparam int GW     = 2;
    localparam int TARGET = 1000;
    localparam int LIMIT  = 60000;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_req;
    logic [N-1:0]    in_ack;
    logic [N*DW-1:0] in_dat;
    logic            out_req;
    logic            out_ack;
    logic [DW-1:0]   out_dat;
    logic [GW-1:0]   grant_idx;
    logic            busy;

    hs_rr_sched #(.N(N), .DW(DW), .SYNC(SYNC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_req    (in_req),
        .in_ack    (in_ack),
        .in_dat    (in_dat),
        .out_req   (out_req),
        .out_ack   (out_ack),
        .out_dat   (out_dat),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dat(input int i, input logic [DW-1:0] d);
        in_dat[i*DW +: DW] = d;
    endtask

    // One full directed transaction with a data-hold probe.
    task automatic serve(input int idx, input logic [DW-1:0] d);
        for (int k = 0; k < 40 && !out_req; k++) tick();
        chk("srv_req", out_req, 1);
        chk("srv_gnt", grant_idx, idx);
        chk("srv_dat", out_dat, d);
        set_dat(idx, ~d);
        tick();
        tick();
        chk("hold_dat", out_dat, d);
        out_ack = 1'b1;
        for (int k = 0; k < 40 && !in_ack[idx]; k++) tick();
        chk("srv_ack", in_ack, 32'd1 << idx);
        in_req[idx] = 1'b0;
        for (int k = 0; k < 40 && out_req; k++) tick();
        chk("srv_rtz", out_req, 0);
        out_ack = 1'b0;
        for (int k = 0; k < 40 && busy; k++) tick();
        chk("srv_idle", {busy, in_ack}, 0);
        chk("hold_dat2", out_dat, d);
    endtask

    int            p_st    [N];
    int            p_dly   [N];
    int            p_raise [N];
    int            wcnt    [N];
    logic [DW-1:0] p_dat   [N];
    int            mptr, cur_w, raised, done, grants, c_dly, w, ci, n;
    bit            prev_busy, quiet, ok;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        in_req  = '0;
        in_dat  = '0;
        out_ack = 1'b0;
        repeat (3) tick();

        chk("rst_out_req", out_req, 0);
        chk("rst_in_ack", in_ack, 0);
        chk("rst_out_dat", out_dat, 0);
        chk("rst_grant", grant_idx, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Single uncontended transfer with latency measurement.
        set_dat(1, 8'hA5);
        in_req[1] = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!out_req && n < 20);
        chk("lat_req", n, SYNC + 2);
        chk("one_gnt", grant_idx, 1);
        chk("one_dat", out_dat, 8'hA5);
        chk("one_busy", busy, 1);
        chk("one_noack", in_ack, 0);
        out_ack = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!in_ack[1] && n < 20);
        chk("lat_ack", n, SYNC + 1);
        chk("one_ack", in_ack, 4'b0010);
        in_req[1] = 1'b0;
        for (int k = 0; k < 40 && out_req; k++) tick();
        chk("one_rtz", out_req, 0);
        out_ack = 1'b0;
        for (int k = 0; k < 40 && busy; k++) tick();
        chk("one_idle", {busy, in_ack}, 0);

        // Reset in the middle of WAIT_RL.
        set_dat(2, 8'h3C);
        in_req[2] = 1'b1;
        for (int k = 0; k < 40 && !out_req; k++) tick();
        chk("mid_gnt", grant_idx, 2);
        out_ack = 1'b1;
        for (int k = 0; k < 40 && !in_ack[2]; k++) tick();
        chk("mid_ack", in_ack, 4'b0100);
        tick();
        rst     = 1'b1;
        in_req  = '0;
        out_ack = 1'b0;
        #1;
        chk("mid_rst", {out_req, in_ack, busy}, 0);
        chk("mid_rst_dat", {grant_idx, out_dat}, 0);
        tick();
        tick();
        rst   = 1'b0;
        quiet = 1'b1;
        repeat (10) begin
            tick();
            quiet &= !out_req && !busy && (in_ack == 0);
        end
        chk("post_rst_quiet", quiet, 1);

        // Contention from ptr=0, then alternation.
        set_dat(0, 8'h10);
        set_dat(1, 8'h11);
        in_req[1:0] = 2'b11;
        serve(0, 8'h10);
        set_dat(0, 8'h20);
        in_req[0] = 1'b1;
        serve(1, 8'h11);
        serve(0, 8'h20);

        // Slow consumer blocks everyone else.
        set_dat(3, 8'h77);
        in_req[3] = 1'b1;
        for (int k = 0; k < 40 && !out_req; k++) tick();
        set_dat(0, 8'h5A);
        in_req[0] = 1'b1;
        ok = 1'b1;
        repeat (50) begin
            tick();
            ok &= out_req && (in_ack == 0) && busy && (grant_idx == 3)
                  && (out_dat == 8'h77);
        end
        chk("slow_hold", ok, 1);
        serve(3, 8'h77);
        serve(0, 8'h5A);

        // Random traffic against the round-robin model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            p_st[i]    = 0;
            p_dly[i]   = $urandom_range(0, 5);
            p_raise[i] = 0;
            wcnt[i]    = 0;
            p_dat[i]   = '0;
        end
        mptr      = 0;
        cur_w     = 0;
        raised    = 0;
        done      = 0;
        grants    = 0;
        c_dly     = 0;
        prev_busy = 1'b0;

        while (done < TARGET && cyc < LIMIT) begin
            tick();
            chk("ack_1hot", $onehot0(in_ack), 1);
            chk("ack_busy", (in_ack != 0) && !busy, 0);

            if (busy && !prev_busy) begin
                w = -1;
                for (int j = 0; j < N; j++) begin
                    ci = (mptr + j) % N;
                    if (w < 0 && p_st[ci] == 1
                        && p_raise[ci] <= cyc - 1 - SYNC)
                        w = ci;
                end
                chk("rnd_found", w >= 0, 1);
                if (w >= 0) begin
                    chk("rnd_gnt", grant_idx, w);
                    chk("rnd_dat", out_dat, p_dat[w]);
                    for (int i = 0; i < N; i++) begin
                        if (i != w && p_st[i] == 1
                            && p_raise[i] <= cyc - 1 - SYNC) begin
                            wcnt[i]++;
                            chk("starve", wcnt[i] > N - 1, 0);
                        end
                    end
                    wcnt[w] = 0;
                    mptr    = (w + 1) % N;
                    cur_w   = w;
                    grants++;
                end
            end
            prev_busy = busy;

            for (int i = 0; i < N; i++) begin
                case (p_st[i])
                    0: begin
                        if (p_dly[i] > 0) p_dly[i]--;
                        else if (raised < TARGET) begin
                            p_dat[i]   = DW'($urandom);
                            set_dat(i, p_dat[i]);
                            in_req[i]  = 1'b1;
                            p_raise[i] = cyc;
                            p_st[i]    = 1;
                            raised++;
                        end
                    end
                    1: begin
                        if (in_ack[i]) begin
                            chk("ack_who", i, cur_w);
                            p_dly[i] = $urandom_range(0, 3);
                            p_st[i]  = 2;
                        end
                    end
                    2: begin
                        if (p_dly[i] > 0) p_dly[i]--;
                        else begin
                            in_req[i] = 1'b0;
                            p_st[i]   = 3;
                        end
                    end
                    default: begin
                        if (!in_ack[i]) begin
                            p_dly[i] = $urandom_range(0, 4);
                            p_st[i]  = 0;
                            done++;
                        end
                    end
                endcase
            end

            if (out_req && !out_ack) begin
                if (c_dly > 0) c_dly--;
                else begin
                    chk("rnd_cdat", out_dat, p_dat[cur_w]);
                    out_ack = 1'b1;
                    c_dly   = $urandom_range(0, 3);
                end
            end else if (!out_req && out_ack) begin
                if (c_dly > 0) c_dly--;
                else begin
                    out_ack = 1'b0;
                    c_dly   = $urandom_range(0, 3);
                end
            end
        end
        chk("rnd_done", done, TARGET);
        chk("rnd_grants", grants, TARGET);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
